// File: rtl/cv32e40px_rf_wb_pkg.sv
// Shared types for the CORE-V-XIF result write-back buffer feeding regfile port W2.
package cv32e40px_rf_wb_pkg;

  localparam int unsigned RF_WB_ADDR_WIDTH  = 6;
  localparam int unsigned RF_WB_DATA_WIDTH  = 32;
  localparam int unsigned RF_WB_FP_BANK_BIT = RF_WB_ADDR_WIDTH - 1;

  typedef struct packed {
    logic [RF_WB_ADDR_WIDTH-1:0]   rd;
    logic                          dual;
    logic [2*RF_WB_DATA_WIDTH-1:0] data;
  } rf_wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI
  } rf_wb_state_e;

  // Partner register of a dual write; stays in the same (integer/FP) bank.
  function automatic logic [RF_WB_ADDR_WIDTH-1:0] rf_wb_hi_addr(
    input logic [RF_WB_ADDR_WIDTH-1:0] rd
  );
    return {rd[RF_WB_FP_BANK_BIT], rd[RF_WB_FP_BANK_BIT-1:1], 1'b1};
  endfunction

endpackage

// File: rtl/cv32e40px_rf_wb_fifo.sv
// Generic synchronous FIFO; exposes its storage and occupancy mask so the
// owner can summarise queued contents.
module cv32e40px_rf_wb_fifo #(
  parameter type         entry_t = logic,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output entry_t                     head,
  output logic [$clog2(DEPTH)-1:0]   head_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DEPTH-1:0]           valid,
  output entry_t                     entries [DEPTH]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] offset;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head     = mem[rd_ptr];
  assign head_ptr = rd_ptr;
  assign entries  = mem;

  // Slot i is occupied when its distance from the read pointer is below count.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - rd_ptr;
      valid[i] = (CNT_W'(offset) < count);
    end
  end

endmodule

// File: rtl/cv32e40px_rf_wb_buffer.sv
// XIF result write-back buffer driving regfile W2; core writes take priority.
// Optional same-cycle bypass of single results: define CV32E40PX_RF_WB_BYPASS_EN.
module cv32e40px_rf_wb_buffer
  import cv32e40px_rf_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_WB_DATA_WIDTH,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_we_i,
  input  logic [ADDR_WIDTH-1:0]    core_waddr_i,
  input  logic [DATA_WIDTH-1:0]    core_wdata_i,
  input  logic                     x_result_valid_i,
  output logic                     x_result_ready_o,
  input  logic                     x_result_we_i,
  input  logic                     x_result_dual_i,
  input  logic [ADDR_WIDTH-1:0]    x_result_rd_i,
  input  logic [2*DATA_WIDTH-1:0]  x_result_data_i,
  output logic                     we_b_o,
  output logic [ADDR_WIDTH-1:0]    waddr_b_o,
  output logic [DATA_WIDTH-1:0]    wdata_b_o,
  output logic [2**ADDR_WIDTH-1:0] pending_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  rf_wb_state_e            state;
  rf_wb_state_e            state_next;
  rf_wb_entry_t            push_entry;
  rf_wb_entry_t            head;
  rf_wb_entry_t            entries [DEPTH];
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [PTR_W-1:0]        head_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [DEPTH-1:0]        fifo_valid;
  logic                    handshake;
  logic                    bypass;
  logic                    drain_we;
  logic [ADDR_WIDTH-1:0]   drain_addr;
  logic [DATA_WIDTH-1:0]   drain_data;
  logic [2**ADDR_WIDTH-1:0] pend;

  assign x_result_ready_o = !rst && !fifo_full;
  assign handshake        = x_result_valid_i && x_result_ready_o;

`ifdef CV32E40PX_RF_WB_BYPASS_EN
  assign bypass = handshake && x_result_we_i && !x_result_dual_i &&
                  (state == IDLE) && fifo_empty && !core_we_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push  = handshake && x_result_we_i && !bypass;
  assign push_entry = '{rd:   x_result_rd_i,
                        dual: x_result_dual_i && !x_result_rd_i[0],
                        data: x_result_data_i};

  cv32e40px_rf_wb_fifo #(
    .entry_t (rf_wb_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .head_ptr  (head_ptr),
    .count     (fifo_count),
    .valid     (fifo_valid),
    .entries   (entries)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // IDLE with a queued entry issues the low write at once, saving a bubble.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    drain_we   = 1'b0;
    drain_addr = head.rd;
    drain_data = head.data[DATA_WIDTH-1:0];
    case (state)
      IDLE, WR_LO: begin
        if (fifo_empty) begin
          state_next = IDLE;
        end else if (!core_we_i) begin
          drain_we = 1'b1;
          if (head.dual) begin
            state_next = WR_HI;
          end else begin
            fifo_pop   = 1'b1;
            state_next = (fifo_count > CNT_W'(1)) ? WR_LO : IDLE;
          end
        end
      end
      WR_HI: begin
        drain_addr = rf_wb_hi_addr(head.rd);
        drain_data = head.data[2*DATA_WIDTH-1:DATA_WIDTH];
        if (!core_we_i) begin
          drain_we   = 1'b1;
          fifo_pop   = 1'b1;
          state_next = (fifo_count > CNT_W'(1)) ? WR_LO : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    we_b_o    = 1'b0;
    waddr_b_o = '0;
    wdata_b_o = '0;
    if (!rst) begin
      if (core_we_i) begin
        we_b_o    = 1'b1;
        waddr_b_o = core_waddr_i;
        wdata_b_o = core_wdata_i;
      end else if (bypass) begin
        we_b_o    = 1'b1;
        waddr_b_o = x_result_rd_i;
        wdata_b_o = x_result_data_i[DATA_WIDTH-1:0];
      end else if (drain_we) begin
        we_b_o    = 1'b1;
        waddr_b_o = drain_addr;
        wdata_b_o = drain_data;
      end
    end
  end

  // Once the low half is written only the partner register is still pending.
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        if (!(state == WR_HI && PTR_W'(i) == head_ptr)) pend[entries[i].rd] = 1'b1;
        if (entries[i].dual) pend[rf_wb_hi_addr(entries[i].rd)] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  assign pending_o = pend;
  assign empty_o   = fifo_empty && (state == IDLE);

endmodule
